// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_LOCK_EN to let a requester keep the grant across back-to-back operations.
module alu_share_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [3*NREQ-1:0]    op_flat,
  input  logic [DW*NREQ-1:0]   a_flat,
  input  logic [DW*NREQ-1:0]   b_flat,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic                 rsp_carry,
  output logic                 rsp_zero,
  output logic                 rsp_ovf,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [2:0]    op_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;

`ifdef ALU_ARB_LOCK_EN
  logic lock_hold;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  // First requester at or above ptr, wrapping around
  logic          arb_found;
  logic [PW-1:0] arb_win;
  int            arb_idx;

  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    arb_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      arb_idx = int'(ptr) + k;
      if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
      if (!arb_found && req[PW'(arb_idx)]) begin
        arb_found = 1'b1;
        arb_win   = PW'(arb_idx);
      end
    end
  end

  logic          sel_valid;
  logic          sel_adv;
  logic [PW-1:0] sel_win;

  always_comb begin
    sel_valid = arb_found;
    sel_win   = arb_win;
    sel_adv   = 1'b1;
`ifdef ALU_ARB_LOCK_EN
    // A locked re-grant bypasses round-robin and leaves ptr untouched
    if (lock_hold && req[win]) begin
      sel_valid = 1'b1;
      sel_win   = win;
      sel_adv   = 1'b0;
    end
`endif
  end

  logic [DW:0]   alu_sum;
  logic [DW-1:0] alu_r;
  logic          alu_c;
  logic          alu_v;
  logic          alu_z;

  always_comb begin
    alu_sum = '0;
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      3'b000: begin
        alu_sum = {1'b0, a_q} + {1'b0, b_q};
        alu_r   = alu_sum[DW-1:0];
        alu_c   = alu_sum[DW];
        alu_v   = (a_q[DW-1] == b_q[DW-1]) && (alu_r[DW-1] != a_q[DW-1]);
      end
      3'b001: begin
        alu_sum = {1'b0, a_q} + {1'b0, ~b_q} + (DW+1)'(1);
        alu_r   = alu_sum[DW-1:0];
        alu_c   = alu_sum[DW];
        alu_v   = (a_q[DW-1] != b_q[DW-1]) && (alu_r[DW-1] != a_q[DW-1]);
      end
      3'b010: alu_r = a_q & b_q;
      3'b011: alu_r = a_q | b_q;
      3'b100: alu_r = a_q ^ b_q;
      3'b101: alu_r = ~a_q;
      3'b110: begin
        alu_r = {a_q[DW-2:0], 1'b0};
        alu_c = a_q[DW-1];
      end
      default: begin
        alu_r = {1'b0, a_q[DW-1:1]};
        alu_c = a_q[0];
      end
    endcase
    alu_z = (alu_r == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_ovf   <= 1'b0;
      busy      <= 1'b0;
      ptr       <= '0;
      win       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
`ifdef ALU_ARB_LOCK_EN
      lock_hold <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= '0;
`ifdef ALU_ARB_LOCK_EN
          lock_hold <= 1'b0;
`endif
          if (sel_valid) begin
            gnt   <= NREQ'(1) << sel_win;
            win   <= sel_win;
            op_q  <= op_flat[3*sel_win +: 3];
            a_q   <= a_flat[DW*sel_win +: DW];
            b_q   <= b_flat[DW*sel_win +: DW];
            busy  <= 1'b1;
            state <= EXEC;
            if (sel_adv) begin
              ptr <= (arb_win == PW'(NREQ-1)) ? '0 : arb_win + PW'(1);
            end
          end
        end
        EXEC: begin
          rsp_data  <= alu_r;
          rsp_carry <= alu_c;
          rsp_zero  <= alu_z;
          rsp_ovf   <= alu_v;
          rsp_valid <= gnt;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= '0;
          gnt       <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
`ifdef ALU_ARB_LOCK_EN
          lock_hold <= lock[win] && req[win];
`endif
        end
        default: begin
          rsp_valid <= '0;
          gnt       <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
